rn_alloc_ctrl: RTL and testbench
================================

# rn_alloc_ctrl

Rename-stage allocation controller for the 2-wide pipeline. Each cycle it decides whether the decoded instruction pair may rename: it checks physical-register availability, ROB space and downstream back-pressure, then drives the rename stall and per-slot allocate grants. It keeps the authoritative free-register count, updated by allocations and retire returns. After a rollback it runs a fixed-length recovery sequence while the map tables and free list restore.

## Interface
- PREG_NUM, 64, total physical registers
- AREG_NUM, 32, architectural registers; free count after reset or rollback is PREG_NUM-AREG_NUM
- RECOVER_CYCLES, 2, stall cycles after a rollback (1..15)
- CNT_W, $clog2(PREG_NUM+1), width of the free count
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inst_valid  in  2  decoded slot i is valid
- need_preg  in  2  slot i writes a non-zero architectural destination; ignored when inst_valid[i]=0
- rob_space  in  2  free ROB entries this cycle, saturated at 2
- dp_stall  in  1  dispatch/RS back-pressure
- rollback_en  in  1  mispredict/violation rollback, one-cycle pulse
- retire_free  in  2  retire slot i returns a T_old to the free list
- alloc_en  out  2  free-list read enables (slot i allocates a preg)
- rn_stall  out  1  hold the ID/RN pipeline register and all map-table writes
- free_cnt  out  CNT_W  registered free-register count
- fl_low  out  1  free_cnt < 2
- recovering  out  1  state is RECOVER
- cnt_err  out  1  sticky: underflow or overflow attempted

## Operation
- States: RUN and RECOVER. Reset puts the block in RUN.
- RUN → RECOVER on rollback_en. RECOVER counts down from RECOVER_CYCLES and returns to RUN when the counter reaches 0.
- rollback_en asserted in any state, including RECOVER, reloads the counter.
- Demand:
  - npreg = number of slots with inst_valid & need_preg (0..2).
  - ninst = popcount(inst_valid).
- rn_stall = recovering | rollback_en | dp_stall | (free_cnt < npreg) | (rob_space < ninst).
- Dispatch is all-or-nothing per pair: when rn_stall=0, alloc_en = inst_valid & need_preg; otherwise alloc_en = 0.
- Count update (RUN, no rollback): free_cnt_next = free_cnt − popcount(alloc_en) + popcount(retire_free).
- Rollback cycle: free_cnt_next = PREG_NUM−AREG_NUM. Same-cycle retire_free and allocations are ignored, because speculative mappings are discarded and the architectural mapping count stays AREG_NUM.
- During RECOVER, retire_free still updates the count, so retires that were already in flight are not lost.
- Saturation:
  - A result below 0 clamps to 0 and sets cnt_err.
  - A result above PREG_NUM−AREG_NUM clamps to PREG_NUM−AREG_NUM and sets cnt_err.
  - cnt_err clears only on reset.
- Arithmetic is done at CNT_W+1 bits signed before clamping.

## Timing
- Reset values:
  - state = RUN, counter = 0, free_cnt = PREG_NUM−AREG_NUM.
  - cnt_err = 0, recovering = 0, fl_low = 0.
  - alloc_en and rn_stall follow the combinational equations.
- alloc_en and rn_stall are combinational from registered state and the current-cycle inputs, so they have zero-cycle latency.
- free_cnt and state update on the rising edge of clock.
- Returned registers are usable the cycle after retire_free; there is no same-cycle bypass.
- Rollback at edge t:
  - rn_stall is high in cycle t (combinational).
  - recovering is high for cycles t+1 … t+RECOVER_CYCLES.
  - The first grant is possible in cycle t+RECOVER_CYCLES+1.
- Reset asserted mid-RECOVER returns the block to RUN immediately (asynchronous).
- When free_cnt = 1 and both slots need a preg, the pair stalls; a single needing slot proceeds.

## Configuration
- RN_ALLOC_CTRL_STATS_EN defined: adds two outputs, both 32-bit saturating counters, reset to 0:
  - stall_cycles: increments every cycle with rn_stall=1 and inst_valid≠0.
  - preg_stall_cycles: increments when free_cnt < npreg causes the stall.
- Undefined: the ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package: `PREG_IDX_WIDTH` and a new enum RN_CTRL_STATE {RN_RUN, RN_RECOVER}.
- One sub-module, rn_free_counter: saturating up/down counter with rollback reload and error flag.
- The FSM and grant logic live in the top module.

## Test plan
- Reset, then inst_valid=2'b11, need_preg=2'b11, rob_space=2 → alloc_en=2'b11, rn_stall=0; next cycle free_cnt=30.
- free_cnt=1, both slots need a preg → rn_stall=1, alloc_en=0. Same cycle retire_free=2'b01 → free_cnt=2 next cycle, then the pair is granted.
- rob_space=1 with two valid slots, need_preg=0 → rn_stall=1; with rob_space=2 → rn_stall=0, alloc_en=0, free_cnt unchanged.
- rollback_en pulse with free_cnt=10 and retire_free=2'b11 → free_cnt=32 next cycle; recovering high for exactly 2 cycles; grants resume in cycle 3.
- Second rollback one cycle into RECOVER → recovering extends to 2 cycles after the second pulse.
- Force retire_free=2'b11 at free_cnt=32 → free_cnt stays 32 and cnt_err=1, persisting until reset.

Source files
------------

// File: rtl/rn_alloc_ctrl_pkg.sv
// Shared types and helpers for the rename-stage allocation controller.
package rn_alloc_ctrl_pkg;

    localparam int PREG_NUM_DEF       = 64;
    localparam int AREG_NUM_DEF       = 32;
    localparam int RECOVER_CYCLES_DEF = 2;
    localparam int PREG_IDX_WIDTH     = $clog2(PREG_NUM_DEF);
    localparam int CNT_W_DEF          = $clog2(PREG_NUM_DEF + 1);

    typedef enum logic {
        RN_RUN,
        RN_RECOVER
    } rn_ctrl_state_e;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rn_alloc_ctrl_if.sv
// Rename-control handshake bundle; stats ports exist only with RN_ALLOC_CTRL_STATS_EN.
interface rn_alloc_ctrl_if #(
    parameter int CNT_W = 7
);
    logic [1:0]       inst_valid;
    logic [1:0]       need_preg;
    logic [1:0]       rob_space;
    logic             dp_stall;
    logic             rollback_en;
    logic [1:0]       retire_free;
    logic [1:0]       alloc_en;
    logic             rn_stall;
    logic [CNT_W-1:0] free_cnt;
    logic             fl_low;
    logic             recovering;
    logic             cnt_err;
`ifdef RN_ALLOC_CTRL_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      preg_stall_cycles;

    modport master (
        output inst_valid, need_preg, rob_space, dp_stall, rollback_en, retire_free,
        input  alloc_en, rn_stall, free_cnt, fl_low, recovering, cnt_err,
        input  stall_cycles, preg_stall_cycles
    );
    modport slave (
        input  inst_valid, need_preg, rob_space, dp_stall, rollback_en, retire_free,
        output alloc_en, rn_stall, free_cnt, fl_low, recovering, cnt_err,
        output stall_cycles, preg_stall_cycles
    );
`else
    modport master (
        output inst_valid, need_preg, rob_space, dp_stall, rollback_en, retire_free,
        input  alloc_en, rn_stall, free_cnt, fl_low, recovering, cnt_err
    );
    modport slave (
        input  inst_valid, need_preg, rob_space, dp_stall, rollback_en, retire_free,
        output alloc_en, rn_stall, free_cnt, fl_low, recovering, cnt_err
    );
`endif
endinterface

// File: rtl/rn_alloc_ctrl_free_counter.sv
// rn_free_counter: saturating free-register counter with rollback reload and sticky error.
module rn_free_counter #(
    parameter int CNT_W   = 7,
    parameter int MAX_CNT = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             reload,
    input  logic [1:0]       dec_n,
    input  logic [1:0]       inc_n,
    output logic [CNT_W-1:0] cnt,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_CNT);

    logic signed [CNT_W:0] sum;
    logic [CNT_W-1:0]      cnt_next;
    logic                  err_next;

    // One extra signed bit lets both underflow and overflow be seen before clamping.
    always_comb begin
        sum      = $signed({1'b0, cnt})
                 - $signed({{(CNT_W-1){1'b0}}, dec_n})
                 + $signed({{(CNT_W-1){1'b0}}, inc_n});
        cnt_next = sum[CNT_W-1:0];
        err_next = err;
        if (reload) begin
            cnt_next = MAX_V;
        end else if (sum < 0) begin
            cnt_next = '0;
            err_next = 1'b1;
        end else if (sum > $signed({1'b0, MAX_V})) begin
            cnt_next = MAX_V;
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= MAX_V;
            err <= 1'b0;
        end else begin
            cnt <= cnt_next;
            err <= err_next;
        end
    end

endmodule

// File: rtl/rn_alloc_ctrl.sv
// Rename allocation controller: stall/grant decision, recovery FSM and free count.
// Optional statistics counters are enabled with RN_ALLOC_CTRL_STATS_EN.
module rn_alloc_ctrl
    import rn_alloc_ctrl_pkg::*;
#(
    parameter int PREG_NUM       = PREG_NUM_DEF,
    parameter int AREG_NUM       = AREG_NUM_DEF,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    parameter int CNT_W          = $clog2(PREG_NUM + 1)
) (
    input logic            clock,
    input logic            reset,
    rn_alloc_ctrl_if.slave bus
);
    rn_ctrl_state_e state, state_next;
    logic [3:0]     rcnt, rcnt_next;
    logic [1:0]     npreg;
    logic [1:0]     ninst;
    logic           preg_short;
    logic           rob_short;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RN_RUN;
            rcnt  <= '0;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
        end
    end

    // A rollback always (re)starts recovery, even when already recovering.
    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        if (bus.rollback_en) begin
            state_next = RN_RECOVER;
            rcnt_next  = 4'(RECOVER_CYCLES);
        end else if (state == RN_RECOVER) begin
            rcnt_next = rcnt - 4'd1;
            if (rcnt <= 4'd1) begin
                state_next = RN_RUN;
                rcnt_next  = '0;
            end
        end
    end

    always_comb begin
        npreg          = pop2(bus.inst_valid & bus.need_preg);
        ninst          = pop2(bus.inst_valid);
        preg_short     = bus.free_cnt < {{(CNT_W-2){1'b0}}, npreg};
        rob_short      = bus.rob_space < ninst;
        bus.recovering = (state == RN_RECOVER);
        bus.rn_stall   = bus.recovering | bus.rollback_en | bus.dp_stall | preg_short | rob_short;
        bus.alloc_en   = bus.rn_stall ? 2'b00 : (bus.inst_valid & bus.need_preg);
        bus.fl_low     = bus.free_cnt < CNT_W'(2);
    end

    rn_free_counter #(
        .CNT_W   (CNT_W),
        .MAX_CNT (PREG_NUM - AREG_NUM)
    ) u_free_counter (
        .clock  (clock),
        .reset  (reset),
        .reload (bus.rollback_en),
        .dec_n  (pop2(bus.alloc_en)),
        .inc_n  (pop2(bus.retire_free)),
        .cnt    (bus.free_cnt),
        .err    (bus.cnt_err)
    );

`ifdef RN_ALLOC_CTRL_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.stall_cycles      <= '0;
            bus.preg_stall_cycles <= '0;
        end else begin
            if (bus.rn_stall && (bus.inst_valid != 2'b00) && (bus.stall_cycles != '1))
                bus.stall_cycles <= bus.stall_cycles + 32'd1;
            if (preg_short && (bus.preg_stall_cycles != '1))
                bus.preg_stall_cycles <= bus.preg_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rn_alloc_ctrl.sv
// Directed bench for rn_alloc_ctrl: vector table plus hand-written recovery/saturation sequences.
module tb_rn_alloc_ctrl;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    rn_alloc_ctrl_if #(.CNT_W(7)) bus ();

    rn_alloc_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] iv;
        logic [1:0] np;
        logic [1:0] rs;
        logic       dp;
        logic [1:0] rf;
        logic [1:0] exp_alloc;
        logic       exp_stall;
        int         exp_free;
    } vec_t;

    vec_t vecs[9];

    task automatic applyStimulus(input logic [1:0] iv, input logic [1:0] np, input logic [1:0] rs,
                                 input logic dp, input logic rb, input logic [1:0] rf);
        bus.inst_valid  = iv;
        bus.need_preg   = np;
        bus.rob_space   = rs;
        bus.dp_stall    = dp;
        bus.rollback_en = rb;
        bus.retire_free = rf;
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00);

        vecs[0] = '{2'b11, 2'b11, 2'd2, 1'b0, 2'b00, 2'b11, 1'b0, 32};
        vecs[1] = '{2'b11, 2'b01, 2'd2, 1'b0, 2'b00, 2'b01, 1'b0, 30};
        vecs[2] = '{2'b11, 2'b00, 2'd1, 1'b0, 2'b00, 2'b00, 1'b1, 29};
        vecs[3] = '{2'b11, 2'b00, 2'd2, 1'b0, 2'b00, 2'b00, 1'b0, 29};
        vecs[4] = '{2'b11, 2'b11, 2'd2, 1'b1, 2'b01, 2'b00, 1'b1, 29};
        vecs[5] = '{2'b10, 2'b10, 2'd1, 1'b0, 2'b00, 2'b10, 1'b0, 30};
        vecs[6] = '{2'b00, 2'b11, 2'd0, 1'b0, 2'b11, 2'b00, 1'b0, 29};
        vecs[7] = '{2'b01, 2'b10, 2'd0, 1'b0, 2'b00, 2'b00, 1'b1, 31};
        vecs[8] = '{2'b11, 2'b10, 2'd2, 1'b0, 2'b10, 2'b10, 1'b0, 31};

        #12;
        checkOutput("reset_free_cnt", int'(bus.free_cnt), 32);
        checkOutput("reset_cnt_err", int'(bus.cnt_err), 0);
        checkOutput("reset_recovering", int'(bus.recovering), 0);
        checkOutput("reset_fl_low", int'(bus.fl_low), 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].iv, vecs[i].np, vecs[i].rs, vecs[i].dp, 1'b0, vecs[i].rf);
            checkOutput($sformatf("vec%0d_free_cnt", i), int'(bus.free_cnt), vecs[i].exp_free);
            checkOutput($sformatf("vec%0d_alloc_en", i), int'(bus.alloc_en), int'(vecs[i].exp_alloc));
            checkOutput($sformatf("vec%0d_rn_stall", i), int'(bus.rn_stall), int'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_recovering", i), int'(bus.recovering), 0);
            tick();
        end
        checkOutput("after_table_free_cnt", int'(bus.free_cnt), 31);

        // Drain to a single free register, then exercise the pair/single boundary.
        for (int i = 0; i < 15; i++) begin
            applyStimulus(2'b11, 2'b11, 2'd2, 1'b0, 1'b0, 2'b00);
            tick();
        end
        applyStimulus(2'b11, 2'b11, 2'd2, 1'b0, 1'b0, 2'b01);
        checkOutput("one_free_cnt", int'(bus.free_cnt), 1);
        checkOutput("one_fl_low", int'(bus.fl_low), 1);
        checkOutput("one_pair_stall", int'(bus.rn_stall), 1);
        checkOutput("one_pair_alloc", int'(bus.alloc_en), 0);
        tick();
        applyStimulus(2'b11, 2'b11, 2'd2, 1'b0, 1'b0, 2'b00);
        checkOutput("two_free_cnt", int'(bus.free_cnt), 2);
        checkOutput("two_fl_low", int'(bus.fl_low), 0);
        checkOutput("two_pair_alloc", int'(bus.alloc_en), 3);
        checkOutput("two_pair_stall", int'(bus.rn_stall), 0);
        tick();
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b01);
        checkOutput("zero_free_cnt", int'(bus.free_cnt), 0);
        tick();
        applyStimulus(2'b11, 2'b01, 2'd2, 1'b0, 1'b0, 2'b00);
        checkOutput("single_alloc", int'(bus.alloc_en), 1);
        checkOutput("single_stall", int'(bus.rn_stall), 0);
        tick();
        checkOutput("single_after_free_cnt", int'(bus.free_cnt), 0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b11);
            tick();
        end
        checkOutput("ten_free_cnt", int'(bus.free_cnt), 10);

        // Rollback at free_cnt=10 with same-cycle retires that must be discarded.
        applyStimulus(2'b11, 2'b11, 2'd2, 1'b0, 1'b1, 2'b11);
        checkOutput("rb_stall", int'(bus.rn_stall), 1);
        checkOutput("rb_alloc", int'(bus.alloc_en), 0);
        tick();
        applyStimulus(2'b11, 2'b11, 2'd2, 1'b0, 1'b0, 2'b00);
        checkOutput("rb_free_cnt", int'(bus.free_cnt), 32);
        checkOutput("rb_recov_t1", int'(bus.recovering), 1);
        checkOutput("rb_stall_t1", int'(bus.rn_stall), 1);
        checkOutput("rb_alloc_t1", int'(bus.alloc_en), 0);
        tick();
        checkOutput("rb_recov_t2", int'(bus.recovering), 1);
        checkOutput("rb_alloc_t2", int'(bus.alloc_en), 0);
        tick();
        checkOutput("rb_recov_t3", int'(bus.recovering), 0);
        checkOutput("rb_alloc_t3", int'(bus.alloc_en), 3);
        checkOutput("rb_stall_t3", int'(bus.rn_stall), 0);
        tick();
        checkOutput("rb_after_free_cnt", int'(bus.free_cnt), 30);

        // Second rollback one cycle into recovery extends it.
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b1, 2'b00);
        tick();
        checkOutput("rb2_first_recov", int'(bus.recovering), 1);
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b1, 2'b00);
        tick();
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00);
        checkOutput("rb2_recov_t1", int'(bus.recovering), 1);
        tick();
        checkOutput("rb2_recov_t2", int'(bus.recovering), 1);
        tick();
        checkOutput("rb2_recov_t3", int'(bus.recovering), 0);
        checkOutput("rb2_free_cnt", int'(bus.free_cnt), 32);

        // Overflow: retires at the ceiling clamp and latch the error.
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b11);
        tick();
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00);
        checkOutput("ovf_free_cnt", int'(bus.free_cnt), 32);
        checkOutput("ovf_cnt_err", int'(bus.cnt_err), 1);
        tick();
        tick();
        checkOutput("ovf_err_sticky", int'(bus.cnt_err), 1);

        // Asynchronous reset in the middle of recovery.
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b1, 2'b00);
        tick();
        applyStimulus(2'b00, 2'b00, 2'd2, 1'b0, 1'b0, 2'b00);
        checkOutput("pre_reset_recov", int'(bus.recovering), 1);
        reset = 1'b1;
        #1;
        checkOutput("async_reset_recov", int'(bus.recovering), 0);
        checkOutput("async_reset_err", int'(bus.cnt_err), 0);
        checkOutput("async_reset_free", int'(bus.free_cnt), 32);
        #3;
        reset = 1'b0;
        tick();
        tick();
        checkOutput("post_reset_recov", int'(bus.recovering), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
